ram_output_fifo: RTL and testbench
==================================

Name: ram_output_fifo

Overview:
- Downstream consumer of the RAM block's read port.
- Captures every word the RAM drives onto its shared read bus for "RAM -> Output" operations (opcode[15:8] = 8'h42).
- Buffers those words in a small FIFO and presents them on a valid/ready stream to the output/display logic, so a stalled consumer never stalls the processor.
- Ignores RAM -> REG traffic (8'h92) and all other opcodes.

Parameters:
- DATA_WIDTH, 16, width of the captured word and of the output stream.
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- PTR_W, 3, log2(DEPTH); pointer width. Count width is PTR_W+1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  DATA_WIDTH  opcode broadcast to every module; bits [15:8] select the operation.
- read_enable  input  1  same read_enable the RAM receives.
- read_data  input  DATA_WIDTH  RAM shared read bus; may be high-Z when not driven.
- clear  input  1  synchronous flush of FIFO contents and the overflow flag.
- out_ready  input  1  downstream can accept a word this cycle.
- out_valid  output  1  FIFO holds at least one word.
- out_data  output  DATA_WIDTH  head-of-FIFO word; meaningful only while out_valid=1.
- count  output  PTR_W+1  number of words currently stored, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; a capture was dropped because the FIFO was full.

Behaviour:
- Capture condition: cap = read_enable && opcode[15:8]==8'h42. read_data is sampled only when cap=1; otherwise it is never used, since Z/X is legal there.
- Push: on a rising edge with cap=1, read_data is written to mem[wr_ptr]. Then wr_ptr+1 (mod DEPTH) and count+1.
- Pop: on a rising edge with out_valid && out_ready, rd_ptr+1 (mod DEPTH) and count-1.
- out_valid = (count != 0). out_data = mem[rd_ptr], show-ahead, no extra register stage.
- Latency:
  - A word captured at edge N is visible on out_data/out_valid immediately after edge N.
  - Earliest pop is at edge N+1.
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - When full, the pop frees the slot, so the push is accepted and overflow is not set.
- Push while full without a pop: the word is dropped. Pointers and count are unchanged, and overflow is set to 1.
- Push while empty: count goes 0->1. No pop happens that cycle, because out_valid was 0 before the edge.
- out_ready while empty: no effect. count must never underflow.
- Pointers wrap modulo DEPTH. count distinguishes full from empty; the pointers alone do not.
- overflow stays at 1 until reset or clear.
- clear has priority over push and pop on the same edge. It sets wr_ptr=rd_ptr=0, count=0 and overflow=0. A concurrent capture is discarded.
- Reset (asynchronous, any time, including mid-stream): wr_ptr=rd_ptr=0, count=0, overflow=0, so out_valid=0 and full=0.
  - Memory contents are not reset; out_data is don't-care while out_valid=0.
  - After reset deasserts, the first capture edge behaves as a push into an empty FIFO.
- No combinational path from out_ready to out_valid or out_data.

Test Plan:
- Reset, then opcode=16'h4205, read_enable=1, read_data=16'h1234 for one cycle, out_ready=0 -> after the edge: out_valid=1, out_data=16'h1234, count=1. Raise out_ready for one cycle -> count=0, out_valid=0.
- opcode=16'h9205, read_enable=1, read_data=16'hBEEF, plus opcode=16'h4105 with read_data=16'hzzzz -> count stays 0, out_valid=0, overflow=0.
- Capture 10 words 16'h0001..16'h000A back-to-back with out_ready=0 -> count=8, full=1, overflow=1. Pop all -> outputs 0001..0008 in order, then out_valid=0; overflow stays 1.
- With the FIFO full (8 words), push 16'hAAAA and pop on the same edge -> count stays 8, overflow stays 0. 16'hAAAA emerges last, after the 7 remaining words.
- Continuous stream of 20 captures with out_ready=1 every cycle (pointer wrap) -> 20 words out in order, count never exceeds 1, overflow=0.
- Load 3 words, assert clear together with a capture of 16'h5555 -> count=0, out_valid=0, overflow=0, and 16'h5555 never appears. Separately, assert reset mid-stream with 5 words stored -> outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ram_output_fifo_if.sv
// ram_output_fifo_if
// Bundles the capture-side and stream-side signals of ram_output_fifo.
//
// Handshake (valid/ready): a word moves from the FIFO to the consumer on a
// rising clk edge exactly when out_valid && out_ready are both 1 before that
// edge. out_valid never depends on out_ready. Once out_valid rises, out_data
// holds the same head word until that word is popped, clear is asserted or
// reset is asserted.
//
// Signals:
//   opcode      producer -> fifo  opcode broadcast; [15:8] selects the operation
//   read_enable producer -> fifo  same read_enable the RAM receives
//   read_data   producer -> fifo  RAM shared read bus (may be Z when idle)
//   clear       producer -> fifo  synchronous flush of contents and overflow
//   out_ready   consumer -> fifo  consumer accepts a word this cycle
//   out_valid   fifo -> consumer  FIFO holds at least one word
//   out_data    fifo -> consumer  head-of-FIFO word
//   count       fifo -> observer  stored words, 0..DEPTH
//   full        fifo -> observer  count == DEPTH
//   overflow    fifo -> observer  sticky: a capture was dropped while full
// Modports: master = environment side, slave = FIFO side.
interface ram_output_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PTR_W      = 3
);
  logic [DATA_WIDTH-1:0] opcode;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  clear;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [PTR_W:0]        count;
  logic                  full;
  logic                  overflow;

  modport master (
    output opcode, read_enable, read_data, clear, out_ready,
    input  out_valid, out_data, count, full, overflow
  );

  modport slave (
    input  opcode, read_enable, read_data, clear, out_ready,
    output out_valid, out_data, count, full, overflow
  );
endinterface

// File: rtl/ram_output_fifo.sv
// ram_output_fifo
// Captures words the RAM drives onto its shared read bus during
// "RAM -> Output" operations (opcode[15:8] == 8'h42) and buffers them in a
// small show-ahead FIFO that feeds the output/display logic over a
// valid/ready stream. A stalled consumer never back-pressures the processor:
// captures arriving while the FIFO is full are dropped and flagged.
//
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous, active-high reset (pointers, count, overflow)
//   bus    ram_output_fifo_if.slave (capture inputs, stream outputs, status)
//
// Parameters:
//   DATA_WIDTH  word width (opcode decode uses bits [15:8], so >= 16)
//   DEPTH       entries, power of two, >= 2
//   PTR_W       log2(DEPTH); count is PTR_W+1 bits wide
module ram_output_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_output_fifo_if.slave     bus
);

  localparam logic [7:0]     OP_RAM_TO_OUT = 8'h42;
  localparam logic [PTR_W:0] FULL_COUNT    = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count_q;
  logic [PTR_W:0]        count_next;
  logic                  overflow_q;

  logic cap;
  logic pop;
  logic push_ok;
  logic drop;
  logic is_full;
  logic is_empty;

  // Low opcode bits carry operands for other blocks; not needed here.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^bus.opcode[7:0];

  assign is_full  = (count_q == FULL_COUNT);
  assign is_empty = (count_q == '0);

  // read_data is only looked at when cap is 1; it may be Z/X otherwise.
  assign cap = bus.read_enable && (bus.opcode[15:8] == OP_RAM_TO_OUT);

  // pop depends only on registered state and out_ready, never feeding back
  // into out_valid/out_data combinationally.
  assign pop = !is_empty && bus.out_ready;

  // A simultaneous pop frees the head slot, so a push into a full FIFO is
  // accepted in that case. The written slot (wr_ptr == rd_ptr when full) is
  // the one being popped on the same edge, so no live word is overwritten.
  assign push_ok = cap && (!is_full || pop);
  assign drop    = cap && is_full && !pop;

  always_comb begin
    count_next = count_q;
    case ({push_ok, pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      // clear wins over any concurrent push or pop.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
      if (drop)    overflow_q <= 1'b1;
    end
  end

  // Storage is not reset; out_data is don't-care while out_valid is 0.
  // Writes are gated on push_ok so a dropped capture never disturbs the
  // head word of a full FIFO.
  always_ff @(posedge clk) begin
    if (push_ok && !bus.clear) begin
      mem[wr_ptr] <= bus.read_data;
    end
  end

  assign bus.out_valid = !is_empty;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ram_output_fifo.sv
// tb_ram_output_fifo
// Directed bench for ram_output_fifo: inputs change 1 ns after each rising
// edge and outputs are checked at that same point, away from the edge.
module tb_ram_output_fifo;

  localparam int DW = 16;
  localparam int PW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [DW-1:0] exp_q[$];

  ram_output_fifo_if #(.DATA_WIDTH(DW), .PTR_W(PW)) bus ();

  ram_output_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .PTR_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.opcode      = 16'h0000;
    bus.read_enable = 1'b0;
    bus.read_data   = 'z;
    bus.clear       = 1'b0;
    bus.out_ready   = 1'b0;
  endtask

  task automatic drive_capture(input logic [DW-1:0] word);
    bus.opcode      = 16'h4205;
    bus.read_enable = 1'b1;
    bus.read_data   = word;
  endtask

  task automatic stop_capture();
    bus.opcode      = 16'h0000;
    bus.read_enable = 1'b0;
    bus.read_data   = 'z;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    drive_capture(16'h1234);
    tick();
    stop_capture();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h1234) begin errors++; $display("FAIL single_data: got %h expected 1234", bus.out_data); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", bus.count); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL single_pop_count: got %0d expected 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_ignore();
    bus.opcode = 16'h9205; bus.read_enable = 1'b1; bus.read_data = 16'hBEEF;
    tick();
    bus.opcode = 16'h4105; bus.read_data = 'z;
    tick();
    // ready while empty must not underflow count
    stop_capture();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL ignore_count: got %0d expected 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ignore_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ignore_overflow: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 10; i++) begin
      drive_capture(DW'(i));
      tick();
    end
    stop_capture();
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", bus.count); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", bus.full); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(i)) begin errors++; $display("FAIL ovf_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.out_valid, bus.out_data, DW'(i)); end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_empty: got %b expected 0", bus.out_valid); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    do_clear();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive_capture(16'h0011 + DW'(i));
      exp_q.push_back(16'h0011 + DW'(i));
      tick();
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b expected 1", bus.full); end
    // push AAAA and pop 0011 on the same edge
    drive_capture(16'hAAAA);
    bus.out_ready = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(16'hAAAA);
    tick();
    stop_capture();
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fpp_count: got %0d expected 8", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b expected 0", bus.overflow); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin errors++; $display("FAIL fpp_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.out_valid, bus.out_data, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic model_valid;
    exp_q.delete();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic [DW-1:0] w;
      w = 16'hC000 + DW'(k * 3);
      drive_capture(w);
      model_valid = (exp_q.size() != 0);
      tick();
      if (model_valid) void'(exp_q.pop_front());
      exp_q.push_back(w);
      checks++; if (bus.count !== 4'(exp_q.size()) || bus.count > 4'd1) begin errors++; $display("FAIL b2b_count_%0d: got %0d expected %0d", k, bus.count, exp_q.size()); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin errors++; $display("FAIL b2b_data_%0d: got valid=%b data=%h expected valid=1 data=%h", k, bus.out_valid, bus.out_data, exp_q[0]); end
    end
    stop_capture();
    tick();
    void'(exp_q.pop_front());
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin errors++; $display("FAIL b2b_final: got valid=%b count=%0d expected valid=0 count=0", bus.out_valid, bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      drive_capture(16'h3000 + DW'(i));
      tick();
    end
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL clr_load: got %0d expected 3", bus.count); end
    drive_capture(16'h5555);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    stop_capture();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b expected 0", bus.overflow); end
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_no_5555: got valid=%b data=%h expected valid=0", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive_capture(16'h6000 + DW'(i));
      tick();
    end
    stop_capture();
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL rst_mid_load: got %0d expected 5", bus.count); end
    #2;
    reset = 1'b1;
    #1;
    // still well before the next rising edge
    checks++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL rst_mid_async: got count=%0d valid=%b full=%b expected 0/0/0", bus.count, bus.out_valid, bus.full); end
    tick();
    reset = 1'b0;
    drive_capture(16'h0077);
    tick();
    stop_capture();
    checks++; if (bus.count !== 4'd1 || bus.out_data !== 16'h0077) begin errors++; $display("FAIL rst_mid_first_push: got count=%0d data=%h expected 1/0077", bus.count, bus.out_data); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_ignore();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
